// File: rtl/idma_nd_midend_tracked_if.sv
// Types and handshake bundle for the ND midend.
// The package fixes the concrete request/response structs; the interface groups
// every frontend/backend handshake plus busy. The midend uses the slave modport,
// the surrounding frontend/backend (or a bench) uses the master modport.
package idma_nd_midend_tracked_pkg;
  localparam int unsigned NumDim    = 3;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned RepWidth  = 32;
  localparam int unsigned LenWidth  = 32;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [1:0]           err_type_t;

  localparam err_type_t BUS_READ  = 2'd0;
  localparam err_type_t BUS_WRITE = 2'd1;
  localparam err_type_t BACKEND   = 2'd2;
  localparam err_type_t ND_MIDEND = 2'd3;

  typedef struct packed {
    logic last;
  } opt_t;

  typedef struct packed {
    logic [LenWidth-1:0] length;
    addr_t               src_addr;
    addr_t               dst_addr;
    opt_t                opt;
  } idma_req_t;

  typedef struct packed {
    err_type_t err_type;
  } rsp_pld_t;

  typedef struct packed {
    logic     last;
    logic     error;
    rsp_pld_t pld;
  } idma_rsp_t;

  typedef struct packed {
    logic [RepWidth-1:0] reps;
    addr_t               src_strides;
    addr_t               dst_strides;
  } d_req_t;

  typedef struct packed {
    idma_req_t               burst_req;
    d_req_t [NumDim-2:0]     d_req;
  } idma_nd_req_t;
endpackage

interface idma_nd_midend_tracked_if;
  import idma_nd_midend_tracked_pkg::*;

  idma_nd_req_t nd_req_i;
  logic         nd_req_valid_i;
  logic         nd_req_ready_o;
  idma_rsp_t    nd_rsp_o;
  logic         nd_rsp_valid_o;
  logic         nd_rsp_ready_i;
  idma_req_t    burst_req_o;
  logic         burst_req_valid_o;
  logic         burst_req_ready_i;
  idma_rsp_t    burst_rsp_i;
  logic         burst_rsp_valid_i;
  logic         burst_rsp_ready_o;
  logic         busy_o;

  modport slave (
    input  nd_req_i, nd_req_valid_i, nd_rsp_ready_i,
    input  burst_req_ready_i, burst_rsp_i, burst_rsp_valid_i,
    output nd_req_ready_o, nd_rsp_o, nd_rsp_valid_o,
    output burst_req_o, burst_req_valid_o, burst_rsp_ready_o, busy_o
  );

  modport master (
    output nd_req_i, nd_req_valid_i, nd_rsp_ready_i,
    output burst_req_ready_i, burst_rsp_i, burst_rsp_valid_i,
    input  nd_req_ready_o, nd_rsp_o, nd_rsp_valid_o,
    input  burst_req_o, burst_req_valid_o, burst_rsp_ready_o, busy_o
  );
endinterface

// File: rtl/idma_nd_midend_tracked.sv
// ND midend: registers one ND job, walks dimensions 2..NumDim issuing 1D bursts
// with a bounded number of outstanding bursts, and folds all backend responses
// into a single ND response.
// Optional: IDMA_ND_MIDEND_ABORT_ON_ERROR_EN stops issuing new bursts once an
// error response has been seen (a burst already presented still completes).
module idma_nd_midend_tracked
  import idma_nd_midend_tracked_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  idma_nd_midend_tracked_if.slave bus
);
  localparam int unsigned ND     = NumDim - 1;
  localparam logic [7:0]  MaxOut = 8'(MaxOutstanding);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]                   state_q, state_d;
  idma_nd_req_t                 job_q, job_d;
  logic [ND-1:0][RepWidth-1:0]  idx_q, idx_d;
  addr_t                        src_q, src_d, dst_q, dst_d;
  logic [7:0]                   out_q, out_d;
  logic                         err_q, err_d;
  idma_rsp_t                    err_rsp_q, err_rsp_d;
  logic                         zero_q, zero_d;
  logic                         pend_q, pend_d;

  logic [ND-1:0][RepWidth-1:0]  last_idx;
  logic [ND-1:0]                at_max, step, wrap;
  logic                         final_burst, abort, req_valid;
  logic                         burst_hs, rsp_hs, req_hs;
  addr_t                        src_inc, dst_inc;
  idma_req_t                    burst_req;
  idma_rsp_t                    nd_rsp;

`ifdef IDMA_ND_MIDEND_ABORT_ON_ERROR_EN
  assign abort = err_q;
`else
  assign abort = 1'b0;
`endif

  // Per-dimension final index: reps of 0 or 1 both mean a single iteration.
  genvar gi;
  for (gi = 0; gi < ND; gi++) begin : g_dim
    assign last_idx[gi] = (job_q.d_req[gi].reps > RepWidth'(1)) ?
                          job_q.d_req[gi].reps - RepWidth'(1) : '0;
    assign at_max[gi]   = (idx_q[gi] == last_idx[gi]);
  end

  // Ripple the increment: a dimension steps if all inner ones are at max and it is not.
  always_comb begin : p_carry
    logic c;
    c    = 1'b1;
    step = '0;
    wrap = '0;
    for (int d = 0; d < ND; d++) begin
      step[d] = c & ~at_max[d];
      wrap[d] = c & at_max[d];
      c       = c & at_max[d];
    end
    final_burst = c;
  end

  // Address advance uses the strides of the single dimension that stepped.
  always_comb begin
    src_inc = '0;
    dst_inc = '0;
    for (int d = 0; d < ND; d++) begin
      if (step[d]) begin
        src_inc = job_q.d_req[d].src_strides;
        dst_inc = job_q.d_req[d].dst_strides;
      end
    end
  end

  // While aborting, only a burst that was already presented may stay valid.
  assign req_valid = (state_q == ISSUE) && (abort ? pend_q : (out_q != MaxOut));
  assign burst_hs  = req_valid & bus.burst_req_ready_i;
  assign rsp_hs    = bus.burst_rsp_valid_i & bus.burst_rsp_ready_o;
  assign req_hs    = bus.nd_req_valid_i & bus.nd_req_ready_o;

  // Next-state logic for the job walker, outstanding counter and error tracking.
  always_comb begin
    state_d   = state_q;
    job_d     = job_q;
    idx_d     = idx_q;
    src_d     = src_q;
    dst_d     = dst_q;
    err_d     = err_q;
    err_rsp_d = err_rsp_q;
    zero_d    = zero_q;
    out_d     = out_q + {7'd0, burst_hs} - {7'd0, rsp_hs};
    pend_d    = req_valid & ~bus.burst_req_ready_i;
    if (rsp_hs && bus.burst_rsp_i.error && !err_q) begin
      err_d     = 1'b1;
      err_rsp_d = bus.burst_rsp_i;
    end
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          job_d     = bus.nd_req_i;
          idx_d     = '0;
          out_d     = '0;
          err_d     = 1'b0;
          err_rsp_d = '0;
          pend_d    = 1'b0;
          src_d     = bus.nd_req_i.burst_req.src_addr;
          dst_d     = bus.nd_req_i.burst_req.dst_addr;
          zero_d    = 1'b1;
          for (int d = 0; d < ND; d++) begin
            if (bus.nd_req_i.d_req[d].reps != '0) zero_d = 1'b0;
          end
          state_d = zero_d ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (burst_hs) begin
          for (int d = 0; d < ND; d++) begin
            if (step[d])      idx_d[d] = idx_q[d] + RepWidth'(1);
            else if (wrap[d]) idx_d[d] = '0;
          end
          src_d = src_q + src_inc;
          dst_d = dst_q + dst_inc;
        end
        if (burst_hs && final_burst)             state_d = DRAIN;
        else if (abort && (!pend_q || burst_hs)) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_d == '0) state_d = RESP;
      end
      default: begin
        if (bus.nd_rsp_ready_i) state_d = IDLE;
      end
    endcase
  end

  // Output payloads are zero outside the states that present them.
  always_comb begin
    burst_req = '0;
    nd_rsp    = '0;
    if (state_q == ISSUE) begin
      burst_req          = job_q.burst_req;
      burst_req.src_addr = src_q;
      burst_req.dst_addr = dst_q;
      burst_req.opt.last = final_burst;
    end
    if (state_q == RESP) begin
      if (err_q) begin
        nd_rsp = err_rsp_q;
      end else if (zero_q) begin
        nd_rsp.error        = 1'b1;
        nd_rsp.pld.err_type = ND_MIDEND;
      end
      nd_rsp.last = 1'b1;
    end
  end

  assign bus.nd_req_ready_o    = (state_q == IDLE);
  assign bus.nd_rsp_valid_o    = (state_q == RESP);
  assign bus.nd_rsp_o          = nd_rsp;
  assign bus.burst_req_valid_o = req_valid;
  assign bus.burst_req_o       = burst_req;
  assign bus.burst_rsp_ready_o = (state_q == ISSUE) || (state_q == DRAIN);
  assign bus.busy_o            = (state_q != IDLE);

  // State registers; reset abandons any job in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      job_q     <= '0;
      idx_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      out_q     <= '0;
      err_q     <= 1'b0;
      err_rsp_q <= '0;
      zero_q    <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      job_q     <= job_d;
      idx_q     <= idx_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      out_q     <= out_d;
      err_q     <= err_d;
      err_rsp_q <= err_rsp_d;
      zero_q    <= zero_d;
      pend_q    <= pend_d;
    end
  end
endmodule

// File: tb/tb_idma_nd_midend_tracked.sv
// Self-checking bench for idma_nd_midend_tracked (MaxOutstanding = 2).
// Expected burst addresses come from a closed-form model: the address of burst k
// is base + sum over dimensions of (non-wrapping steps of that dimension) * stride.
module tb_idma_nd_midend_tracked;
  import idma_nd_midend_tracked_pkg::*;

  localparam int MAX_OUT = 2;
  localparam int ND      = NumDim - 1;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   errors = 0;

  idma_nd_midend_tracked_if bus();

  idma_nd_midend_tracked #(.MaxOutstanding(MAX_OUT)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic addr_t model_addr(input idma_nd_req_t r, input bit is_src, input longint k);
    addr_t  a, s;
    longint p, e, n;
    a = is_src ? r.burst_req.src_addr : r.burst_req.dst_addr;
    p = 1;
    for (int j = 0; j < ND; j++) begin
      e = (r.d_req[j].reps <= 1) ? 1 : longint'(r.d_req[j].reps);
      n = k / p - k / (p * e);
      s = is_src ? r.d_req[j].src_strides : r.d_req[j].dst_strides;
      a = a + addr_t'(n) * s;
      p = p * e;
    end
    return a;
  endfunction

  task automatic init_inputs();
    bus.nd_req_i          = '0;
    bus.nd_req_valid_i    = 1'b0;
    bus.nd_rsp_ready_i    = 1'b0;
    bus.burst_req_ready_i = 1'b0;
    bus.burst_rsp_i       = '0;
    bus.burst_rsp_valid_i = 1'b0;
  endtask

  task automatic send_req(input idma_nd_req_t r);
    bus.nd_req_i       = r;
    bus.nd_req_valid_i = 1'b1;
    #1;
    checks++;
    if (bus.nd_req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL nd_req_ready: got %b want 1", bus.nd_req_ready_o);
    end
    @(posedge clk_i); #1;
    bus.nd_req_valid_i = 1'b0;
    bus.nd_req_i       = '0;
  endtask

  // mode 0: random ready/responses; 1: always ready, immediate responses;
  // 2: always ready, responses withheld then released one every third cycle.
  task automatic run_job(input idma_nd_req_t r, input int mode, input int err_idx,
                         input int stall, output int n_bursts);
    longint    total;
    bit        zero, done, hs, rv, rsp_hs, prev_stall, prev_nd_stall;
    idma_rsp_t exp_rsp;
    idma_req_t exp_req, prev_req;
    int        pend, avail, rsps, k, cyc, stall_left;
    zero = 1'b1; total = 1;
    for (int j = 0; j < ND; j++) begin
      if (r.d_req[j].reps != 0) zero = 1'b0;
      total = total * ((r.d_req[j].reps <= 1) ? 1 : longint'(r.d_req[j].reps));
    end
    if (zero) total = 0;
    exp_rsp = '0;
    exp_rsp.last = 1'b1;
    if (zero) begin
      exp_rsp.error = 1'b1; exp_rsp.pld.err_type = ND_MIDEND;
    end else if (err_idx >= 0 && err_idx < total) begin
      exp_rsp.error = 1'b1; exp_rsp.pld.err_type = BUS_WRITE;
    end
    pend = 0; rsps = 0; k = 0; cyc = 0; done = 1'b0;
    prev_stall = 1'b0; prev_nd_stall = 1'b0; prev_req = '0; stall_left = stall;
    send_req(r);
    checks++;
    if (zero && bus.nd_rsp_valid_o !== 1'b1) begin
      errors++; $display("FAIL zero_rsp_cycle1: nd_rsp_valid got %b want 1", bus.nd_rsp_valid_o);
    end else if (!zero && bus.burst_req_valid_o !== 1'b1) begin
      errors++; $display("FAIL first_burst_cycle1: burst_req_valid got %b want 1", bus.burst_req_valid_o);
    end
    while (!done && cyc < 2000) begin
      bus.burst_req_ready_i = (mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      hs = bus.burst_req_valid_o && bus.burst_req_ready_i;
      if (prev_stall) begin
        checks++;
        if (bus.burst_req_valid_o !== 1'b1 || bus.burst_req_o !== prev_req) begin
          errors++;
          $display("FAIL burst_stable: got valid=%b req=%h want valid=1 req=%h",
                   bus.burst_req_valid_o, bus.burst_req_o, prev_req);
        end
      end
      if (hs) begin
        checks++;
        if (pend >= MAX_OUT) begin
          errors++; $display("FAIL outstanding_limit: burst issued with %0d outstanding, limit %0d", pend, MAX_OUT);
        end
        exp_req          = r.burst_req;
        exp_req.src_addr = model_addr(r, 1'b1, longint'(k));
        exp_req.dst_addr = model_addr(r, 1'b0, longint'(k));
        exp_req.opt.last = (longint'(k) == total - 1);
        checks++;
        if (bus.burst_req_o !== exp_req) begin
          errors++;
          $display("FAIL burst[%0d]: got src=%h dst=%h last=%b want src=%h dst=%h last=%b", k,
                   bus.burst_req_o.src_addr, bus.burst_req_o.dst_addr, bus.burst_req_o.opt.last,
                   exp_req.src_addr, exp_req.dst_addr, exp_req.opt.last);
        end
        k++;
      end
      prev_stall = bus.burst_req_valid_o && !bus.burst_req_ready_i;
      prev_req   = bus.burst_req_o;
      if (mode == 2 && cyc == 4) begin
        checks++;
        if (k != MAX_OUT || bus.burst_req_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL limit_hold: got %0d bursts valid=%b want %0d bursts valid=0", k, bus.burst_req_valid_o, MAX_OUT);
        end
      end
      avail = pend + int'(hs);
      case (mode)
        0:       rv = (avail > 0) && ($urandom_range(0, 1) == 1);
        1:       rv = (avail > 0);
        default: rv = (avail > 0) && (cyc >= 6) && (cyc % 3 == 0);
      endcase
      bus.burst_rsp_valid_i = rv;
      bus.burst_rsp_i       = '0;
      if (rv && rsps == err_idx) begin
        bus.burst_rsp_i.error        = 1'b1;
        bus.burst_rsp_i.pld.err_type = BUS_WRITE;
      end
      if (prev_nd_stall && bus.nd_rsp_valid_o !== 1'b1) begin
        checks++; errors++;
        $display("FAIL nd_rsp_held: valid dropped during stall, got %b want 1", bus.nd_rsp_valid_o);
      end
      bus.nd_rsp_ready_i = 1'b0;
      if (bus.nd_rsp_valid_o) begin
        checks++;
        if (bus.nd_rsp_o !== exp_rsp || rsps != k) begin
          errors++;
          $display("FAIL nd_rsp: got %h after %0d/%0d responses want %h with all answered",
                   bus.nd_rsp_o, rsps, k, exp_rsp);
        end
        if (stall_left > 0) stall_left--;
        else bus.nd_rsp_ready_i = 1'b1;
      end
      prev_nd_stall = bus.nd_rsp_valid_o && !bus.nd_rsp_ready_i;
      done = bus.nd_rsp_valid_o && bus.nd_rsp_ready_i;
      #1;
      rsp_hs = rv && bus.burst_rsp_ready_o;
      pend   = avail - int'(rsp_hs);
      rsps   = rsps + int'(rsp_hs);
      @(posedge clk_i); #1;
      cyc++;
    end
    bus.burst_rsp_valid_i = 1'b0;
    bus.burst_rsp_i       = '0;
    bus.nd_rsp_ready_i    = 1'b0;
    bus.burst_req_ready_i = 1'b0;
    checks++;
    if (!done) begin
      errors++; $display("FAIL timeout: no ND response after %0d cycles", cyc);
    end else if (bus.busy_o !== 1'b0) begin
      errors++; $display("FAIL busy_after_job: got %b want 0", bus.busy_o);
    end
    if (err_idx < 0) begin
      checks++;
      if (longint'(k) != total) begin
        errors++; $display("FAIL burst_count: got %0d want %0d", k, total);
      end
    end
    n_bursts = k;
  endtask

  function automatic idma_nd_req_t mk_req(input addr_t src, input addr_t dst,
                                          input int r2, input addr_t s2, input addr_t t2,
                                          input int r3, input addr_t s3, input addr_t t3);
    idma_nd_req_t r;
    r = '0;
    r.burst_req.length        = 32'h40;
    r.burst_req.src_addr      = src;
    r.burst_req.dst_addr      = dst;
    r.d_req[0].reps           = RepWidth'(r2);
    r.d_req[0].src_strides    = s2;
    r.d_req[0].dst_strides    = t2;
    r.d_req[1].reps           = RepWidth'(r3);
    r.d_req[1].src_strides    = s3;
    r.d_req[1].dst_strides    = t3;
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (bus.nd_req_ready_o !== 1'b1 || bus.nd_rsp_valid_o !== 1'b0 || bus.burst_req_valid_o !== 1'b0 ||
        bus.burst_rsp_ready_o !== 1'b0 || bus.busy_o !== 1'b0 ||
        bus.burst_req_o !== '0 || bus.nd_rsp_o !== '0) begin
      errors++;
      $display("FAIL %s: got rdy=%b rspv=%b bv=%b brr=%b busy=%b breq=%h rsp=%h want 1 0 0 0 0 0 0", tag,
               bus.nd_req_ready_o, bus.nd_rsp_valid_o, bus.burst_req_valid_o, bus.burst_rsp_ready_o,
               bus.busy_o, bus.burst_req_o, bus.nd_rsp_o);
    end
  endtask

  task automatic test_reset();
    check_idle_outputs("reset_values");
  endtask

  task automatic test_2d();
    int n;
    run_job(mk_req(32'h1000, 32'h2000, 3, 32'h40, 32'h80, 0, 0, 0), 1, -1, 0, n);
    $display("2d job: %0d bursts", n);
  endtask

  task automatic test_3d();
    int n;
    run_job(mk_req(32'h0, 32'h0, 2, 32'h10, 32'h10, 2, 32'h100, 32'h100), 1, -1, 0, n);
    $display("3d job: %0d bursts", n);
  endtask

  task automatic test_outstanding();
    int n;
    run_job(mk_req(32'h4000, 32'h8000, 5, 32'h20, 32'h20, 1, 32'h1, 32'h1), 2, -1, 0, n);
    $display("outstanding job: %0d bursts", n);
  endtask

  task automatic test_zero();
    int n;
    run_job(mk_req(32'h1234, 32'h5678, 0, 32'h4, 32'h4, 0, 32'h8, 32'h8), 1, -1, 0, n);
    $display("zero job: %0d bursts", n);
  endtask

  task automatic test_error();
    int n;
    run_job(mk_req(32'h100, 32'h200, 4, 32'h10, 32'h20, 0, 0, 0), 1, 1, 0, n);
    checks++;
`ifdef IDMA_ND_MIDEND_ABORT_ON_ERROR_EN
    if (n > 3) begin
      errors++; $display("FAIL abort_count: got %0d bursts want at most 3", n);
    end
`else
    if (n != 4) begin
      errors++; $display("FAIL error_count: got %0d bursts want 4", n);
    end
`endif
    $display("error job: %0d bursts", n);
  endtask

  task automatic test_random();
    idma_nd_req_t r;
    int n;
    for (int t = 0; t < 8; t++) begin
      r = mk_req($urandom, $urandom, $urandom_range(0, 4), $urandom, $urandom,
                 $urandom_range(0, 4), $urandom, $urandom);
      r.burst_req.length   = $urandom;
      r.burst_req.opt.last = 1'($urandom_range(0, 1));
      run_job(r, 0, -1, $urandom_range(0, 3), n);
      $display("random job %0d: reps=%0d,%0d %0d bursts", t, r.d_req[0].reps, r.d_req[1].reps, n);
    end
  endtask

  task automatic test_backpressure_reset();
    int n;
    run_job(mk_req(32'hA000, 32'hB000, 3, 32'h8, 32'h8, 0, 0, 0), 1, -1, 5, n);
    $display("stalled response job: %0d bursts", n);
    send_req(mk_req(32'h0, 32'h0, 6, 32'h4, 32'h4, 0, 0, 0));
    bus.burst_req_ready_i = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (bus.busy_o !== 1'b1) begin
      errors++; $display("FAIL busy_in_issue: got %b want 1", bus.busy_o);
    end
    rst_ni = 1'b0;
    #1;
    check_idle_outputs("reset_mid_job");
    bus.burst_req_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check_idle_outputs("after_reset_release");
    $display("reset mid-job done");
  endtask

  initial begin
    init_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    test_reset();
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    test_2d();
    test_3d();
    test_outstanding();
    test_zero();
    test_error();
    test_random();
    test_backpressure_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
